// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out MSB-first,
// repeating it a programmable number of times with a programmable idle gap between copies.
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_reg, pat_nxt;
    logic [REP_W-1:0] reps_left, reps_nxt;
    logic [GAP_W-1:0] gap_reg, gap_reg_nxt;
    logic [GAP_W-1:0] gap_ctr, gap_ctr_nxt;
    logic [IDX_W-1:0] bit_idx, idx_nxt;
    logic [IDX_W-1:0] sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pat_reg   <= '0;
            reps_left <= '0;
            gap_reg   <= '0;
            gap_ctr   <= '0;
            bit_idx   <= '0;
        end else begin
            state     <= state_nxt;
            pat_reg   <= pat_nxt;
            reps_left <= reps_nxt;
            gap_reg   <= gap_reg_nxt;
            gap_ctr   <= gap_ctr_nxt;
            bit_idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pat_nxt     = pat_reg;
        reps_nxt    = reps_left;
        gap_reg_nxt = gap_reg;
        gap_ctr_nxt = gap_ctr;
        idx_nxt     = bit_idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pat_nxt     = pat_in;
                    reps_nxt    = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
                    gap_reg_nxt = gap;
                    idx_nxt     = '0;
                    state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_idx == LAST_IDX) begin
                    // A zero gap restarts the next copy directly, with no dead cycle.
                    if (reps_left > REP_W'(1)) begin
                        reps_nxt = reps_left - REP_W'(1);
                        idx_nxt  = '0;
                        if (gap_reg != '0) begin
                            state_nxt   = ST_GAP;
                            gap_ctr_nxt = gap_reg;
                        end
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    idx_nxt = bit_idx + IDX_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_ctr <= GAP_W'(1)) begin
                    gap_ctr_nxt = '0;
                    idx_nxt     = '0;
                    state_nxt   = ST_SHIFT;
                end else begin
                    gap_ctr_nxt = gap_ctr - GAP_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    assign sel       = LAST_IDX - bit_idx;
    assign out_valid = (state == ST_SHIFT);
    assign out_bit   = out_valid & pat_reg[sel];
    assign busy      = (state == ST_SHIFT) || (state == ST_GAP);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected per-cycle {busy,done,out_valid,out_bit}
// vectors are queued when a transfer is launched and compared on every falling edge.
module tb_seq_pattern_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] pat_in;
    logic [3:0] rep_cnt;
    logic [3:0] gap;
    logic       out_bit;
    logic       out_valid;
    logic       busy;
    logic       done;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];

    seq_pattern_gen #(.PAT_W(4), .REP_W(4), .GAP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .pat_in   (pat_in),
        .rep_cnt  (rep_cnt),
        .gap      (gap),
        .out_bit  (out_bit),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Every falling edge consumes one expected vector; an empty queue means idle outputs.
    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 4'b0000;
        check_val("bus/done/vld/bit", {28'd0, busy, done, out_valid, out_bit}, {28'd0, e});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected output stream of one transfer started now; limit<0 keeps all of it.
    task automatic push_model(input logic [3:0] pat, input logic [3:0] rep,
                              input logic [3:0] g, input int limit);
        logic [3:0] v[$];
        int r;
        r = (rep == 4'd0) ? 1 : int'(rep);
        v.push_back(4'b0000);
        for (int c = 0; c < r; c++) begin
            for (int b = 3; b >= 0; b--) v.push_back({3'b101, pat[b]});
            if (c < r - 1)
                for (int k = 0; k < int'(g); k++) v.push_back(4'b1000);
        end
        v.push_back(4'b0100);
        for (int i = 0; i < v.size() && (limit < 0 || i < limit); i++) exp_q.push_back(v[i]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        check_val("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_xfer(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] g);
        pat_in  = pat;
        rep_cnt = rep;
        gap     = g;
        start   = 1'b1;
        push_model(pat, rep, g, -1);
        tick();
        start   = 1'b0;
        pat_in  = 4'($urandom);
        rep_cnt = 4'($urandom);
        gap     = 4'($urandom);
        wait_drain();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pat_in  = 4'b0;
        rep_cnt = 4'b0;
        gap     = 4'b0;
        #2;
        check_val("reset outs", {28'd0, busy, done, out_valid, out_bit}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_xfer(4'b1011, 4'd1, 4'd0);
        run_xfer(4'b1011, 4'd2, 4'd0);
        run_xfer(4'b1101, 4'd2, 4'd3);
        run_xfer(4'b1001, 4'd3, 4'd1);
        run_xfer(4'b0101, 4'd2, 4'd15);
        run_xfer(4'b1110, 4'd15, 4'd0);

        // rep_cnt=0 sends one copy; starts during SHIFT and during DONE are ignored
        pat_in  = 4'b0110;
        rep_cnt = 4'd0;
        gap     = 4'd0;
        start   = 1'b1;
        push_model(4'b0110, 4'd0, 4'd0, -1);
        tick();
        start = 1'b0;
        tick();
        start  = 1'b1;
        pat_in = 4'b1111;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_drain();
        repeat (3) tick();

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();

        // abort sampled at the end of the 3rd bit of a 3-copy transfer
        pat_in  = 4'b1011;
        rep_cnt = 4'd3;
        gap     = 4'd0;
        start   = 1'b1;
        push_model(4'b1011, 4'd3, 4'd0, 4);
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_drain();
        repeat (3) tick();
        run_xfer(4'b1011, 4'd1, 4'd0);

        // asynchronous reset in the third gap cycle
        pat_in  = 4'b1101;
        rep_cnt = 4'd2;
        gap     = 4'd3;
        start   = 1'b1;
        push_model(4'b1101, 4'd2, 4'd3, 7);
        tick();
        start = 1'b0;
        wait_drain();
        #1 reset = 1'b0;
        #1;
        check_val("async reset outs", {28'd0, busy, done, out_valid, out_bit}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_xfer(4'b1110, 4'd1, 4'd0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
